// File: rtl/tlul_pkg.sv
// Shared TL-UL channel types and widths used by bus-attached peripherals.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_DUW = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DW/8-1:0]    a_mask;
    logic [TL_DW-1:0]      a_data;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic [TL_DUW-1:0]     d_user;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_adapter_pkg.sv
// FIFO entry layouts and A-channel legality check for the TL-UL to SRAM adapter.
package tlul_sram_adapter_pkg;
  import tlul_pkg::*;

  typedef struct packed {
    tl_a_op_e          opcode;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic              err;
  } req_entry_t;

  typedef struct packed {
    logic [TL_DW-1:0] data;
    logic             err;
  } rsp_entry_t;

  // Byte lanes covered by an access of the given size at the given byte offset.
  function automatic logic [3:0] addr_bytes(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << offs;
      2'd1:    be = offs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic a_req_err(input tl_h2d_t tl);
    logic [3:0] be;
    logic       bad_op, bad_size, misalign, bad_full, stray;
    be       = addr_bytes(tl.a_size, tl.a_address[1:0]);
    bad_op   = !(tl.a_opcode inside {PutFullData, PutPartialData, Get});
    bad_size = (tl.a_size == 2'd3);
    misalign = ((tl.a_size == 2'd1) && tl.a_address[0]) ||
               ((tl.a_size == 2'd2) && (tl.a_address[1:0] != 2'b00));
    bad_full = (tl.a_opcode == PutFullData) && ((tl.a_mask & be) != be);
    stray    = ((tl.a_mask & ~be) != 4'b0000);
    return bad_op | bad_size | misalign | bad_full | stray;
  endfunction

endpackage

// File: rtl/tlul_sync_fifo.sv
// Synchronous FIFO with optional fall-through (write data visible at the output in the same cycle).
module tlul_sync_fifo #(
  parameter int unsigned Width       = 8,
  parameter int unsigned Depth       = 1,
  parameter bit          FallThrough = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  // Entries at or above Depth are never written and stay at their reset value.
  logic [Width-1:0] mem_q [2**PtrW];
  logic [Width-1:0] mem_d [2**PtrW];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty, full, push, pop, bypass, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign rvalid_o = !empty || (FallThrough && wvalid_i);
  assign rdata_o  = (FallThrough && empty) ? wdata_i : mem_q[rptr_q];
  assign wready_o = !full || rready_i;
  assign push     = wvalid_i && wready_o;
  assign pop      = rvalid_o && rready_i;
  assign bypass   = FallThrough && empty && pop;
  assign do_push  = push && !bypass;
  assign do_pop   = pop && !bypass;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tlul_sram_adapter.sv
// TL-UL device port to single-port SRAM request interface; in-order responses, Outstanding deep.
module tlul_sram_adapter
  import tlul_pkg::*;
  import tlul_sram_adapter_pkg::*;
#(
  parameter int unsigned SramAw      = 12,
  parameter int unsigned SramDw      = 32,
  parameter int unsigned Outstanding = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [SramDw-1:0] wdata_o,
  output logic [SramDw-1:0] wmask_o,
  input  logic [SramDw-1:0] rdata_i,
  input  logic              rvalid_i,
  input  logic [1:0]        rerror_i
);

  localparam int unsigned PendW = $clog2(Outstanding + 1);

  logic             a_err, a_ready, a_hs;
  req_entry_t       req_wdata, req_rdata;
  logic             req_wready, req_rvalid, req_pop;
  rsp_entry_t       rsp_wdata, rsp_rdata;
  logic             rsp_push, rsp_rvalid, rsp_pop;
  logic             head_rd, d_valid;
  logic [PendW-1:0] pend_q, pend_d;
  logic             unused_rsp_wready, unused_bits;

  assign a_err   = a_req_err(tl_i);
  assign req_o   = tl_i.a_valid && !a_err && req_wready;
  assign a_ready = req_wready && (a_err || gnt_i);
  assign a_hs    = tl_i.a_valid && a_ready;

  assign we_o    = (tl_i.a_opcode != Get);
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = tl_i.a_data;
  always_comb begin
    wmask_o = '0;
    for (int i = 0; i < TL_DW / 8; i++) begin
      wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
    end
  end

  assign req_wdata = '{opcode: tl_i.a_opcode, size: tl_i.a_size,
                       source: tl_i.a_source, err: a_err};

  tlul_sync_fifo #(
    .Width       ($bits(req_entry_t)),
    .Depth       (Outstanding),
    .FallThrough (1'b0)
  ) u_req_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (a_hs),
    .wready_o (req_wready),
    .wdata_i  (req_wdata),
    .rvalid_o (req_rvalid),
    .rready_i (req_pop),
    .rdata_o  (req_rdata)
  );

  // Only read data that belongs to a granted read is captured; stray strobes are dropped.
  assign rsp_push  = rvalid_i && (pend_q != '0);
  assign rsp_wdata = '{data: rdata_i, err: rerror_i[1]};

  tlul_sync_fifo #(
    .Width       ($bits(rsp_entry_t)),
    .Depth       (Outstanding),
    .FallThrough (1'b1)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (rsp_push),
    .wready_o (unused_rsp_wready),
    .wdata_i  (rsp_wdata),
    .rvalid_o (rsp_rvalid),
    .rready_i (rsp_pop),
    .rdata_o  (rsp_rdata)
  );

  always_comb begin
    pend_d = pend_q + PendW'(req_o && gnt_i && !we_o) - PendW'(rsp_push);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign head_rd = (req_rdata.opcode == Get) && !req_rdata.err;
  assign d_valid = req_rvalid && (!head_rd || rsp_rvalid);
  assign req_pop = d_valid && tl_i.d_ready;
  assign rsp_pop = req_pop && head_rd;

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = (req_rdata.opcode == Get) ? AccessAckData : AccessAck;
    tl_o.d_size   = req_rdata.size;
    tl_o.d_source = req_rdata.source;
    tl_o.d_data   = head_rd ? rsp_rdata.data : '0;
    tl_o.d_error  = req_rdata.err || (head_rd && rsp_rdata.err);
    tl_o.a_ready  = a_ready;
  end

  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:SramAw+2], rerror_i[0]};

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Directed bench for tlul_sram_adapter with hand-computed expected responses.
module tb_tlul_sram_adapter;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        req_o, gnt_i, we_o, rvalid_i;
  logic [11:0] addr_o;
  logic [31:0] wdata_o, wmask_o, rdata_i;
  logic [1:0]  rerror_i;

  logic [31:0] mem [0:63];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk_i = ~clk_i;

  tlul_sram_adapter #(.SramAw(12), .SramDw(32), .Outstanding(1)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tl_i     (tl_i),
    .tl_o     (tl_o),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .wmask_o  (wmask_o),
    .rdata_i  (rdata_i),
    .rvalid_i (rvalid_i),
    .rerror_i (rerror_i)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = tl_a_op_e'(op);
    tl_i.a_address = addr;
    tl_i.a_size    = size;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  // One complete transaction with d_ready=1: accept, response one cycle later, pop.
  task automatic do_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data,
                        input logic [7:0] src, input logic exp_req, input logic [31:0] exp_wmask,
                        input logic [2:0] exp_dop, input logic exp_err, input logic [31:0] exp_data,
                        input logic [1:0] rerr);
    logic is_rd;
    @(posedge clk_i); #1;
    drive_a(op, addr, size, mask, data, src);
    @(negedge clk_i);
    check({tag, ".a_ready"}, tl_o.a_ready, 1'b1);
    check({tag, ".req"}, req_o, exp_req);
    check({tag, ".dv_pre"}, tl_o.d_valid, 1'b0);
    if (exp_req) begin
      check({tag, ".addr"}, addr_o, addr[13:2]);
      check({tag, ".we"}, we_o, (op != 3'd4));
      if (op != 3'd4) check({tag, ".wmask"}, wmask_o, exp_wmask);
    end
    @(posedge clk_i); #1;
    is_rd = exp_req && (op == 3'd4);
    if (exp_req && op != 3'd4)
      mem[addr[7:2]] = (mem[addr[7:2]] & ~exp_wmask) | (data & exp_wmask);
    tl_i.a_valid = 1'b0;
    if (is_rd) begin
      rvalid_i = 1'b1;
      rdata_i  = mem[addr[7:2]];
      rerror_i = rerr;
    end
    @(negedge clk_i);
    check({tag, ".d_valid"}, tl_o.d_valid, 1'b1);
    check({tag, ".d_opcode"}, tl_o.d_opcode, exp_dop);
    check({tag, ".d_error"}, tl_o.d_error, exp_err);
    check({tag, ".d_data"}, tl_o.d_data, exp_data);
    check({tag, ".d_source"}, tl_o.d_source, src);
    check({tag, ".d_size"}, tl_o.d_size, size);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0;
    rerror_i = 2'b00;
    @(negedge clk_i);
    check({tag, ".d_idle"}, tl_o.d_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    tl_i         = '0;
    tl_i.d_ready = 1'b1;
    gnt_i        = 1'b1;
    rvalid_i     = 1'b0;
    rdata_i      = 32'h0;
    rerror_i     = 2'b00;
    rst_ni       = 1'b0;
    #12;
    check("rst.d_valid", tl_o.d_valid, 1'b0);
    check("rst.a_ready", tl_o.a_ready, 1'b1);
    check("rst.req", req_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //      tag          op    addr   sz  mask     data          src  req wmask          dop err data           rerr
    do_txn("wr_full",   3'd0, 32'h8, 2, 4'b1111, 32'h0000_ABCD, 8'd3, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         2'b00);
    do_txn("rd_8",      3'd4, 32'h8, 2, 4'b1111, 32'h0,         8'd5, 1, 32'h0,         1, 0, 32'h0000_ABCD, 2'b00);
    do_txn("wr_part",   3'd1, 32'h4, 2, 4'b0001, 32'h0000_0012, 8'd1, 1, 32'h0000_00FF, 0, 0, 32'h0,         2'b00);
    do_txn("wr_byte1",  3'd1, 32'h5, 0, 4'b0010, 32'h0000_3400, 8'd2, 1, 32'h0000_FF00, 0, 0, 32'h0,         2'b00);
    do_txn("rd_4",      3'd4, 32'h4, 2, 4'b1111, 32'h0,         8'd7, 1, 32'h0,         1, 0, 32'h0000_3412, 2'b00);
    do_txn("err_align", 3'd4, 32'h2, 2, 4'b1111, 32'h0,         8'd9, 0, 32'h0,         1, 1, 32'h0,         2'b00);
    do_txn("err_op3",   3'd3, 32'h0, 2, 4'b1111, 32'h0,         8'd4, 0, 32'h0,         0, 1, 32'h0,         2'b00);
    do_txn("err_size3", 3'd4, 32'h0, 3, 4'b1111, 32'h0,         8'd6, 0, 32'h0,         1, 1, 32'h0,         2'b00);
    do_txn("err_full",  3'd0, 32'h8, 2, 4'b0111, 32'h1,         8'd8, 0, 32'h0,         0, 1, 32'h0,         2'b00);
    do_txn("err_stray", 3'd1, 32'h5, 0, 4'b0001, 32'h1,         8'd2, 0, 32'h0,         0, 1, 32'h0,         2'b00);
    do_txn("rd_rerr",   3'd4, 32'h8, 2, 4'b1111, 32'h0,         8'd3, 1, 32'h0,         1, 1, 32'h0000_ABCD, 2'b10);
    do_txn("rd_rerr0",  3'd4, 32'h8, 2, 4'b1111, 32'h0,         8'd3, 1, 32'h0,         1, 0, 32'h0000_ABCD, 2'b01);
    do_txn("wr_55aa",   3'd0, 32'h10, 2, 4'b1111, 32'h0000_55AA, 8'd1, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,        2'b00);

    // Back-pressure: response held, second Get stalls until the pop cycle.
    @(posedge clk_i); #1;
    tl_i.d_ready = 1'b0;
    drive_a(3'd4, 32'h10, 2, 4'b1111, 32'h0, 8'd11);
    @(negedge clk_i);
    check("bp.first_ready", tl_o.a_ready, 1'b1);
    @(posedge clk_i); #1;
    rvalid_i = 1'b1;
    rdata_i  = mem[4];
    drive_a(3'd4, 32'h8, 2, 4'b1111, 32'h0, 8'd12);
    @(negedge clk_i);
    check("bp.dv0", tl_o.d_valid, 1'b1);
    check("bp.data0", tl_o.d_data, 32'h0000_55AA);
    check("bp.stall0", tl_o.a_ready, 1'b0);
    check("bp.noreq0", req_o, 1'b0);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0;
    rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("bp.dv1", tl_o.d_valid, 1'b1);
    check("bp.data1", tl_o.d_data, 32'h0000_55AA);
    check("bp.src1", tl_o.d_source, 8'd11);
    check("bp.stall1", tl_o.a_ready, 1'b0);
    @(posedge clk_i); #1;
    tl_i.d_ready = 1'b1;
    @(negedge clk_i);
    check("bp.pop_ready", tl_o.a_ready, 1'b1);
    check("bp.pop_req", req_o, 1'b1);
    @(posedge clk_i); #1;
    tl_i.a_valid = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = mem[2];
    @(negedge clk_i);
    check("bp.dv2", tl_o.d_valid, 1'b1);
    check("bp.data2", tl_o.d_data, 32'h0000_ABCD);
    check("bp.src2", tl_o.d_source, 8'd12);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0;
    @(negedge clk_i);
    check("bp.idle", tl_o.d_valid, 1'b0);

    // Reset the cycle after a Get accept; the in-flight and a stray rvalid must be dropped.
    @(posedge clk_i); #1;
    drive_a(3'd4, 32'h8, 2, 4'b1111, 32'h0, 8'd13);
    @(negedge clk_i);
    check("rmid.accept", tl_o.a_ready, 1'b1);
    @(posedge clk_i); #1;
    tl_i.a_valid = 1'b0;
    rst_ni   = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = 32'hDEAD_0001;
    #1;
    check("rmid.dv_rst", tl_o.d_valid, 1'b0);
    @(posedge clk_i); #1;
    rst_ni  = 1'b1;
    rdata_i = 32'hDEAD_0002;
    @(negedge clk_i);
    check("rmid.dv_after", tl_o.d_valid, 1'b0);
    check("rmid.a_ready", tl_o.a_ready, 1'b1);
    @(posedge clk_i); #1;
    rvalid_i = 1'b0;
    do_txn("rmid_rd", 3'd4, 32'h8, 2, 4'b1111, 32'h0, 8'd14, 1, 32'h0, 1, 0, 32'h0000_ABCD, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
